// File: rtl/prot_eng_tx_mc.sv
// Multi-template TX protocol engine: prepends one of NUM_HDRS settings-programmed headers
// to each packet on the 36-bit {occ,eof,sof,data} FIFO stream. Optional: PROT_ENG_LEN_FIXUP_EN.
module prot_eng_tx_mc #(
  parameter int BASE      = 128,
  parameter int NUM_HDRS  = 4,
  parameter int HDR_LINES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [35:0] datain,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [35:0] dataout,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i
);

  localparam int TMPL_WORDS = NUM_HDRS * HDR_LINES;
  localparam int CFG_BASE   = BASE + TMPL_WORDS;
  localparam int CFG_END    = CFG_BASE + NUM_HDRS;
  localparam int TSEL_W     = (NUM_HDRS > 1) ? $clog2(NUM_HDRS) : 1;
  localparam int HLEN_W     = $clog2(HDR_LINES) + 1;
  localparam int TIDX_W     = (TMPL_WORDS > 1) ? $clog2(TMPL_WORDS) : 1;

  generate
    if (CFG_END > 256 || NUM_HDRS < 1 || NUM_HDRS > 8 ||
        (NUM_HDRS & (NUM_HDRS - 1)) != 0 || (HDR_LINES & (HDR_LINES - 1)) != 0) begin : g_bad_params
      $error("prot_eng_tx_mc: illegal BASE/NUM_HDRS/HDR_LINES combination");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BODY} state_e;

  // Settings decode
  logic [8:0]        addr_ext;
  logic              tmpl_we;
  logic              cfg_we;
  logic [TIDX_W-1:0] tmpl_waddr;
  logic [TSEL_W-1:0] cfg_waddr;
  logic [HLEN_W-1:0] cfg_len_d;

  // NOTE: every variable driven in always_comb gets a default at the top, so no path can infer a latch.
  always_comb begin
    addr_ext   = {1'b0, set_addr};
    tmpl_we    = set_stb && (addr_ext >= 9'(BASE)) && (addr_ext < 9'(CFG_BASE));
    cfg_we     = set_stb && (addr_ext >= 9'(CFG_BASE)) && (addr_ext < 9'(CFG_END));
    tmpl_waddr = TIDX_W'(addr_ext - 9'(BASE));
    cfg_waddr  = TSEL_W'(addr_ext - 9'(CFG_BASE));
    cfg_len_d  = (int'(set_data[4:0]) > HDR_LINES) ? HLEN_W'(HDR_LINES) : HLEN_W'(set_data[4:0]);
  end

  logic [31:0] tmpl_mem [TMPL_WORDS];

  // NOTE: the template RAM is deliberately left without a reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (tmpl_we) tmpl_mem[tmpl_waddr] <= set_data;
  end

  logic [HLEN_W-1:0] cfg_len_q [NUM_HDRS];
`ifdef PROT_ENG_LEN_FIXUP_EN
  logic [4:0]        cfg_fix_q [NUM_HDRS];
`endif

  // NOTE: sequential state is only ever assigned with <=, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < NUM_HDRS; t++) begin
        cfg_len_q[t] <= '0;
`ifdef PROT_ENG_LEN_FIXUP_EN
        cfg_fix_q[t] <= '0;
`endif
      end
    end else if (cfg_we) begin
      cfg_len_q[cfg_waddr] <= cfg_len_d;
`ifdef PROT_ENG_LEN_FIXUP_EN
      cfg_fix_q[cfg_waddr] <= set_data[12:8];
`endif
    end
  end

  // Packet state: template select, header length and eof are frozen at control-word time
  state_e            state_q;
  logic [TSEL_W-1:0] tsel_q;
  logic [HLEN_W-1:0] hlen_q;
  logic [HLEN_W-1:0] hcnt_q;
  logic              ctl_eof_q;
  logic              first_body_q;
`ifdef PROT_ENG_LEN_FIXUP_EN
  logic [15:0]       plen_q;
  logic [4:0]        fix_idx_q;
`endif

  logic [TSEL_W-1:0] ctl_tsel;
  logic [HLEN_W-1:0] ctl_hlen;
  logic              in_xfer;
  logic              out_xfer;
  logic              last_hdr;

  always_comb begin
    ctl_tsel = datain[16 +: TSEL_W] & TSEL_W'(NUM_HDRS - 1);
    ctl_hlen = cfg_len_q[ctl_tsel];
    in_xfer  = src_rdy_i && dst_rdy_o;
    out_xfer = src_rdy_o && dst_rdy_i;
    last_hdr = (hcnt_q == hlen_q - HLEN_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tsel_q       <= '0;
      hlen_q       <= '0;
      hcnt_q       <= '0;
      ctl_eof_q    <= 1'b0;
      first_body_q <= 1'b0;
`ifdef PROT_ENG_LEN_FIXUP_EN
      plen_q       <= '0;
      fix_idx_q    <= '0;
`endif
    end else if (clear) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      first_body_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Non-sof lines in IDLE are dropped so the engine resyncs on the next control word
          if (in_xfer && datain[32]) begin
            tsel_q       <= ctl_tsel;
            hlen_q       <= ctl_hlen;
            ctl_eof_q    <= datain[33];
            hcnt_q       <= '0;
            first_body_q <= (ctl_hlen == '0);
`ifdef PROT_ENG_LEN_FIXUP_EN
            plen_q       <= datain[15:0];
            fix_idx_q    <= cfg_fix_q[ctl_tsel];
`endif
            if (ctl_hlen != '0)  state_q <= ST_HDR;
            else if (!datain[33]) state_q <= ST_BODY;
          end
        end
        ST_HDR: begin
          if (out_xfer) begin
            if (last_hdr) begin
              hcnt_q  <= '0;
              state_q <= ctl_eof_q ? ST_IDLE : ST_BODY;
            end else begin
              hcnt_q  <= hcnt_q + HLEN_W'(1);
            end
          end
        end
        ST_BODY: begin
          if (in_xfer) begin
            first_body_q <= 1'b0;
            if (datain[33]) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output path is combinational so header and body stream without bubbles
  logic [TIDX_W-1:0] tmpl_ridx;
  logic [31:0]       hdr_word;

  always_comb begin
    tmpl_ridx = TIDX_W'(int'(tsel_q) * HDR_LINES + int'(hcnt_q));
    hdr_word  = tmpl_mem[tmpl_ridx];
`ifdef PROT_ENG_LEN_FIXUP_EN
    if (int'(hcnt_q) == int'(fix_idx_q)) hdr_word[15:0] = hdr_word[15:0] + plen_q;
`endif
  end

  always_comb begin
    dataout   = '0;
    src_rdy_o = 1'b0;
    dst_rdy_o = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        ST_IDLE: dst_rdy_o = 1'b1;
        ST_HDR: begin
          src_rdy_o = 1'b1;
          dataout   = {2'b00, last_hdr && ctl_eof_q, hcnt_q == '0, hdr_word};
        end
        ST_BODY: begin
          src_rdy_o = src_rdy_i;
          dst_rdy_o = dst_rdy_i;
          dataout   = {datain[35:33], first_body_q, datain[31:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prot_eng_tx_mc.sv
// Directed self-checking bench for prot_eng_tx_mc; also covers the PROT_ENG_LEN_FIXUP_EN build.
module tb_prot_eng_tx_mc;

  localparam int BASE      = 128;
  localparam int NUM_HDRS  = 4;
  localparam int HDR_LINES = 16;
  localparam int CFG_BASE  = BASE + NUM_HDRS * HDR_LINES;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [35:0] datain;
  logic        src_rdy_i;
  logic        dst_rdy_o;
  logic [35:0] dataout;
  logic        src_rdy_o;
  logic        dst_rdy_i;

  always #5 clk = ~clk;

  prot_eng_tx_mc #(.BASE(BASE), .NUM_HDRS(NUM_HDRS), .HDR_LINES(HDR_LINES)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .datain   (datain),
    .src_rdy_i(src_rdy_i),
    .dst_rdy_o(dst_rdy_o),
    .dataout  (dataout),
    .src_rdy_o(src_rdy_o),
    .dst_rdy_i(dst_rdy_i)
  );

  int n_checks = 0;
  int n_errors = 0;
  int last_cyc;
  logic [35:0] in_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] ln(input logic [1:0] occ, input logic eof, input logic sof,
                                     input logic [31:0] d);
    return {occ, eof, sof, d};
  endfunction

  task automatic set_reg(input int addr, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = 8'(addr);
    set_data = d;
    @(posedge clk); #1;
    set_stb  = 1'b0;
  endtask

  // Streams in_q into the DUT, collects every output transfer and compares against exp_q.
  task automatic send(input string tag, input bit bp);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    got_q.delete();
    while ((idx < in_q.size() || got_q.size() < exp_q.size()) && cyc < 300) begin
      src_rdy_i = (idx < in_q.size());
      datain    = (idx < in_q.size()) ? in_q[idx] : 36'h0;
      dst_rdy_i = bp ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (src_rdy_o && dst_rdy_i) got_q.push_back(dataout);
      if (src_rdy_i && dst_rdy_o) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    last_cyc = cyc;
    repeat (3) begin
      src_rdy_i = 1'b0;
      datain    = 36'h0;
      dst_rdy_i = 1'b1;
      #1;
      if (src_rdy_o) got_q.push_back(dataout);
      @(posedge clk); #1;
    end
    check({tag, " out count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s line %0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    dst_rdy_i = 1'b0;
    #1;
    check({tag, " back in idle"}, 64'(dst_rdy_o), 64'd1);
    dst_rdy_i = 1'b1;
  endtask

  task automatic load_pkt1();
    in_q  = '{ln(0, 0, 1, 32'h0000_000C), ln(0, 0, 0, 32'hA0B0_C0D0),
              ln(0, 0, 0, 32'hA1B1_C1D1), ln(0, 1, 0, 32'hA2B2_C2D2)};
    exp_q = '{ln(0, 0, 1, 32'h89AB_CDEF), ln(0, 0, 0, 32'h1111_2222), ln(0, 0, 0, 32'h3333_4444),
              ln(0, 0, 0, 32'hA0B0_C0D0), ln(0, 0, 0, 32'hA1B1_C1D1), ln(0, 1, 0, 32'hA2B2_C2D2)};
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    set_stb   = 1'b0;
    set_addr  = 8'h0;
    set_data  = 32'h0;
    datain    = ln(0, 0, 1, 32'h0000_0003);
    src_rdy_i = 1'b1;
    dst_rdy_i = 1'b1;
    #12;
    check("reset dst_rdy_o", 64'(dst_rdy_o), 64'd0);
    check("reset src_rdy_o", 64'(src_rdy_o), 64'd0);
    check("reset dataout", 64'(dataout), 64'd0);
    src_rdy_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    check("idle dst_rdy_o", 64'(dst_rdy_o), 64'd1);
    check("idle src_rdy_o", 64'(src_rdy_o), 64'd0);

    // Basic prepend; fix_idx=31 lies beyond hdr_len so the line is verbatim in either build
    set_reg(BASE + 0, 32'h89AB_CDEF);
    set_reg(BASE + 1, 32'h1111_2222);
    set_reg(BASE + 2, 32'h3333_4444);
    set_reg(CFG_BASE + 0, 32'h0000_1F03);
    load_pkt1();
    send("t1 prepend", 1'b0);
    check("t1 cycles", 64'(last_cyc), 64'd7);

    // Template select plus occ; an in-body sof must not survive
    set_reg(BASE + 2 * HDR_LINES + 0, 32'hCAFE_0001);
    set_reg(BASE + 2 * HDR_LINES + 1, 32'hCAFE_0002);
    set_reg(CFG_BASE + 2, 32'h0000_1F02);
    in_q  = '{ln(0, 0, 1, 32'h0002_000B), ln(0, 0, 0, 32'h1111_1111),
              ln(0, 0, 1, 32'h2222_2222), ln(3, 1, 0, 32'h3333_3333)};
    exp_q = '{ln(0, 0, 1, 32'hCAFE_0001), ln(0, 0, 0, 32'hCAFE_0002), ln(0, 0, 0, 32'h1111_1111),
              ln(0, 0, 0, 32'h2222_2222), ln(3, 1, 0, 32'h3333_3333)};
    send("t2 select", 1'b0);

    // Stray line dropped, zero-length header gives sof on the body line
    set_reg(CFG_BASE + 1, 32'h0000_1F00);
    in_q  = '{ln(0, 0, 0, 32'hDEAD_BEEF), ln(0, 0, 1, 32'h0001_0004), ln(0, 1, 0, 32'h1234_5678)};
    exp_q = '{ln(0, 1, 1, 32'h1234_5678)};
    send("t3 zero hdr", 1'b0);

    // Control-only packets
    in_q  = '{ln(0, 1, 1, 32'h0000_0000)};
    exp_q = '{ln(0, 0, 1, 32'h89AB_CDEF), ln(0, 0, 0, 32'h1111_2222), ln(0, 1, 0, 32'h3333_4444)};
    send("t4 ctl only", 1'b0);
    set_reg(CFG_BASE + 0, 32'h0000_1F00);
    exp_q = {};
    send("t4 dropped", 1'b0);
    set_reg(CFG_BASE + 0, 32'h0000_1F03);

    // hdr_len of 20 saturates to 16 lines
    for (int i = 0; i < HDR_LINES; i++) set_reg(BASE + 3 * HDR_LINES + i, 32'h3000_0000 + i);
    set_reg(CFG_BASE + 3, 32'h0000_0014);
    in_q  = '{ln(0, 1, 1, 32'h0003_0000)};
    exp_q = {};
    for (int i = 0; i < HDR_LINES; i++)
      exp_q.push_back(ln(0, i == HDR_LINES - 1, i == 0, 32'h3000_0000 + i));
    send("t4 saturate", 1'b0);

    // Backpressure and back-to-back packets
    load_pkt1();
    send("t5 backpressure", 1'b1);
    load_pkt1();
    in_q  = {in_q, in_q};
    exp_q = {exp_q, exp_q};
    send("t5 back2back", 1'b0);
    check("t5 b2b cycles", 64'(last_cyc), 64'd14);

    // Clear mid-header
    datain = ln(0, 0, 1, 32'h0000_000C); src_rdy_i = 1'b1; dst_rdy_i = 1'b1;
    @(posedge clk); #1;
    datain = ln(0, 0, 0, 32'h5555_5555); dst_rdy_i = 1'b0;
    #1;
    check("hdr dst_rdy_o", 64'(dst_rdy_o), 64'd0);
    check("hdr src_rdy_o", 64'(src_rdy_o), 64'd1);
    check("hdr first line", 64'(dataout), 64'(ln(0, 0, 1, 32'h89AB_CDEF)));
    clear = 1'b1; src_rdy_i = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    check("clear in hdr", 64'(dst_rdy_o), 64'd1);

    // Clear mid-body
    datain = ln(0, 0, 1, 32'h0001_0008); src_rdy_i = 1'b1; dst_rdy_i = 1'b1;
    @(posedge clk); #1;
    datain = ln(0, 0, 0, 32'h7777_7777);
    #1;
    check("body first", 64'(dataout), 64'(ln(0, 0, 1, 32'h7777_7777)));
    check("body src_rdy_o", 64'(src_rdy_o), 64'd1);
    @(posedge clk); #1;
    datain = ln(0, 0, 0, 32'h8888_8888);
    #1;
    check("body second", 64'(dataout), 64'(ln(0, 0, 0, 32'h8888_8888)));
    clear = 1'b1; src_rdy_i = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0; dst_rdy_i = 1'b0;
    #1;
    check("clear in body", 64'(dst_rdy_o), 64'd1);
    dst_rdy_i = 1'b1;
    load_pkt1();
    send("t5 after clear", 1'b0);

    // Length fixup on header line 1
    set_reg(BASE + 1, 32'h0011_001C);
    set_reg(CFG_BASE + 0, 32'h0000_0103);
    in_q = '{ln(0, 1, 1, 32'h0000_0010)};
`ifdef PROT_ENG_LEN_FIXUP_EN
    exp_q = '{ln(0, 0, 1, 32'h89AB_CDEF), ln(0, 0, 0, 32'h0011_002C), ln(0, 1, 0, 32'h3333_4444)};
    send("t6 fixup", 1'b0);
    set_reg(BASE + 1, 32'h0011_0020);
    in_q  = '{ln(0, 1, 1, 32'h0000_FFF0)};
    exp_q = '{ln(0, 0, 1, 32'h89AB_CDEF), ln(0, 0, 0, 32'h0011_0010), ln(0, 1, 0, 32'h3333_4444)};
    send("t6 fixup wrap", 1'b0);
`else
    exp_q = '{ln(0, 0, 1, 32'h89AB_CDEF), ln(0, 0, 0, 32'h0011_001C), ln(0, 1, 0, 32'h3333_4444)};
    send("t6 verbatim", 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prot_eng_tx_mc.md
Name: prot_eng_tx_mc

Overview:
- Multi-template successor of the single-header TX protocol engine: prepends one of NUM_HDRS settings-programmed header templates to each packet on a 36-bit FIFO stream {occ[1:0],eof,sof,data[31:0]}.
- Sits between the TX packet FIFO and ethtx_realign.
- The first input line of each packet is a control word. It selects the template and carries the payload byte length. It is consumed and never forwarded.

Parameters:
- BASE, 128: first settings address of the block.
- NUM_HDRS, 4: number of header templates, power of 2, range 1..8.
- HDR_LINES, 16: maximum header length in 32-bit lines per template, power of 2.
- Constraint: BASE + NUM_HDRS*HDR_LINES + NUM_HDRS <= 256, checked at elaboration.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort to IDLE
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- datain  in  36  {occ,eof,sof,data}
- src_rdy_i  in  1  input valid
- dst_rdy_o  out  1  input accept
- dataout  out  36  {occ,eof,sof,data}
- src_rdy_o  out  1  output valid
- dst_rdy_i  in  1  downstream ready

Behaviour:

Settings map:
- Template RAM: BASE + t*HDR_LINES + i writes template t, line i (32-bit word).
- Config register t: BASE + NUM_HDRS*HDR_LINES + t.
  - [4:0] hdr_len: 0..HDR_LINES; values above HDR_LINES saturate to HDR_LINES.
  - [12:8] fix_idx: used only under the optional feature.
- Writes outside the block's range are ignored.

Reset:
- Asynchronous on reset_n low: state=IDLE, counters=0, config regs=0.
- Template RAM is not reset.
- While reset_n is low: src_rdy_o=0, dst_rdy_o=0, dataout=0.

Handshake:
- A line transfers on a cycle where src_rdy && dst_rdy are both high.
- Output is combinational from the state, header RAM and datain: zero-latency pass-through, no bubbles between header and body.

FSM:
- IDLE
  - dst_rdy_o=1, src_rdy_o=0.
  - On a transfer with sof=1: latch tsel = data[16 +: log2(NUM_HDRS)], plen = data[15:0], hlen = cfg[tsel].hdr_len, ctl_eof = eof. Clear hcnt.
  - Next state: HDR if hlen!=0; else BODY if !eof; else stay IDLE (packet dropped).
  - On a transfer with sof=0: line is discarded (resync), stay IDLE.
- HDR
  - dst_rdy_o=0, src_rdy_o=1.
  - dataout = {2'b00, last_hdr && ctl_eof, hcnt==0, tmpl[tsel][hcnt]}, where last_hdr = (hcnt==hlen-1).
  - On each output transfer hcnt increments.
  - After the last header line: go to BODY, or to IDLE if ctl_eof.
- BODY
  - Pass-through: dataout = {occ,eof,1'b0,data}, with sof forced to 0 unless hlen==0 and this is the first body line.
  - src_rdy_o = src_rdy_i, dst_rdy_o = dst_rdy_i.
  - On a transfer with eof=1: go to IDLE.
  - An input sof=1 seen in BODY is treated as an ordinary data line; sof is not regenerated.

Boundary conditions:
- hlen==0 with a non-eof control word: the first body line carries sof=1.
- hlen is latched at control time. Config writes mid-packet affect only later packets.
- Template RAM writes mid-packet take effect immediately. Software must not rewrite the active template.
- clear: next cycle state=IDLE, counters=0. Any partially sent packet is truncated with no eof; downstream must also be cleared.
- Back-to-back packets: IDLE accepts the next control word in the cycle after the body eof transfer. Each packet costs exactly one idle output cycle.

Optional Feature:
- Macro: PROT_ENG_LEN_FIXUP_EN
- Defined:
  - When hcnt == cfg.fix_idx during HDR, output data[15:0] = tmpl[15:0] + plen, modulo 2^16; data[31:16] unchanged.
  - Supports IP/UDP length fields, with the template holding header overhead, e.g. 28.
  - fix_idx >= hlen: no effect.
- Undefined:
  - Template lines are emitted verbatim.
  - fix_idx bits are writable but ignored; no adder is synthesised.

Test Plan:
1. Basic prepend:
   - Program tmpl0 = 89ABCDEF,11112222,33334444 with hdr_len=3.
   - Send ctrl 0000_000C then A0B0C0D0, A1B1C1D1, A2B2C2D2 (eof, occ=0).
   - Required output: 3 header lines (sof on the first), then 3 payload lines, eof on the last.
2. Template select plus occ:
   - tmpl2 with hdr_len=2; ctrl 0002_000B; payload 3 lines, last occ=3.
   - Required output: tmpl2 lines, then payload with occ=3 and eof preserved.
3. Zero header and resync:
   - Send a stray non-sof line in IDLE: it is dropped.
   - cfg1 hdr_len=0, ctrl 0001_0004, one payload line: output is a single line with sof=1, eof=1.
4. Control-only packets:
   - ctrl 0000_0000 with eof and hdr_len=3: 3 lines, the last with eof.
   - Same with hdr_len=0: nothing output.
5. Backpressure and clear:
   - Toggle dst_rdy_i 1010 throughout: no lost or duplicated lines.
   - Assert clear mid-BODY, then send a new packet: it is emitted correctly from sof.
6. Length fixup (PROT_ENG_LEN_FIXUP_EN):
   - tmpl0 line 1 = 0011_001C, fix_idx=1, ctrl 0000_0010.
   - Required: header line 1 = 0011_002C.
   - plen=FFF0 with template 0020: result wraps to 0010.
